// File: rtl/test_harness.sv
// test_harness: self-checking shift-add multiplier driven by a Galois LFSR.
// Each iteration loads two 16-bit operands from the LFSR and builds their
// product one bit per cycle. It then compares the result against a
// combinational reference product.
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous active-low reset
//   io_success - high while the FSM sits in DONE (all iterations matched)
module test_harness #(
    parameter int unsigned NUM_ITERS  = 1000,
    parameter logic [31:0] SEED       = 32'hACE1_2468,
    parameter int unsigned FAULT_ITER = 0
) (
    input  logic clock,
    input  logic reset,
    output logic io_success
);
    // The all-zero seed is a lock-up state for the LFSR, so substitute 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [2:0] {LOAD, MUL, CHECK, DONE, ERROR} state_t;

    state_t      state, state_nx;
    logic [31:0] lfsr, acc, prod;
    logic [15:0] a, b, iter;
    logic [3:0]  cnt;
    logic        fault, match;

    assign prod  = 32'(a) * 32'(b);
    // iter counts completed iterations, so the current one is iter + 1.
    assign fault = (FAULT_ITER != 0) && (({1'b0, iter} + 17'd1) == 17'(FAULT_ITER));
    assign match = (acc ^ {31'd0, fault}) == prod;
    assign io_success = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = MUL;
            MUL:     state_nx = (cnt == 4'd15) ? CHECK : MUL;
            CHECK:   state_nx = !match ? ERROR :
                                ((iter + 16'd1) == 16'(NUM_ITERS)) ? DONE : LOAD;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            lfsr  <= SEED_EFF;
            acc   <= 32'd0;
            cnt   <= 4'd0;
            iter  <= 16'd0;
            a     <= 16'd0;
            b     <= 16'd0;
        end else begin
            state <= state_nx;
            case (state)
                LOAD: begin
                    a    <= lfsr[31:16];
                    b    <= lfsr[15:0];
                    acc  <= 32'd0;
                    cnt  <= 4'd0;
                    lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'd0);
                end
                MUL: begin
                    acc <= acc + (b[cnt] ? (32'(a) << cnt) : 32'd0);
                    cnt <= cnt + 4'd1;
                end
                CHECK: iter <= match ? iter + 16'd1 : iter;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_test_harness.sv
// tb_test_harness: scoreboard bench for several test_harness configurations.
module tb_test_harness;
    logic clk = 1'b0;
    logic rst_main = 1'b0;
    logic rst3 = 1'b0;
    logic s0, s1, s2, s3, s4, s5;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon0_en = 1'b1;
    logic [31:0] q0[$], q1[$], q4[$], q5[$];

    always #5 clk = ~clk;

    test_harness u0 (.clock(clk), .reset(rst_main), .io_success(s0));
    test_harness #(.NUM_ITERS(1), .SEED(32'h0003_0005)) u1 (.clock(clk), .reset(rst_main), .io_success(s1));
    test_harness #(.NUM_ITERS(10), .FAULT_ITER(3)) u2 (.clock(clk), .reset(rst_main), .io_success(s2));
    test_harness #(.NUM_ITERS(8)) u3 (.clock(clk), .reset(rst3), .io_success(s3));
    test_harness #(.NUM_ITERS(1), .SEED(32'hFFFF_FFFF)) u4 (.clock(clk), .reset(rst_main), .io_success(s4));
    test_harness #(.NUM_ITERS(1), .SEED(32'h0)) u5 (.clock(clk), .reset(rst_main), .io_success(s5));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_nx(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic push_singles();
        q1.push_back(32'd15);
        q4.push_back(32'hFFFE_0001);
        q5.push_back(32'd0);
    endtask

    // Monitor: whenever an instance sits in CHECK, pop its expected product.
    always @(negedge clk) begin
        if (mon0_en && u0.state == 3'd2) begin
            if (q0.size() == 0) chk("u0_extra_check", 1, 0);
            else chk("u0_acc", u0.acc, q0.pop_front());
        end
        if (u1.state == 3'd2) begin
            if (q1.size() == 0) chk("u1_extra_check", 1, 0);
            else chk("u1_acc", u1.acc, q1.pop_front());
        end
        if (u4.state == 3'd2) begin
            if (q4.size() == 0) chk("u4_extra_check", 1, 0);
            else chk("u4_acc", u4.acc, q4.pop_front());
        end
        if (u5.state == 3'd2) begin
            if (q5.size() == 0) chk("u5_extra_check", 1, 0);
            else chk("u5_acc", u5.acc, q5.pop_front());
        end
    end

    initial begin
        logic [31:0] l;
        l = 32'hACE1_2468;
        for (int i = 0; i < 1000; i++) begin
            q0.push_back({16'd0, l[31:16]} * {16'd0, l[15:0]});
            l = lfsr_nx(l);
        end
        push_singles();
        repeat (3) @(negedge clk);
        chk("rst_s0", s0, 0);
        chk("rst_s1", s1, 0);
        chk("rst_state", u0.state, 0);
        chk("rst_lfsr", u0.lfsr, 32'hACE1_2468);
        chk("rst_seed0_lfsr", u5.lfsr, 32'h1);
        chk("rst_acc", u4.acc, 0);
        rst_main = 1'b1;
        rst3 = 1'b1;
        fork
            begin
                repeat (17) @(posedge clk);
                #1;
                chk("u1_edge17", s1, 0);
                chk("u4_edge17", s4, 0);
                chk("u5_edge17", s5, 0);
                @(posedge clk);
                #1;
                chk("u1_edge18", s1, 1);
                chk("u4_edge18", s4, 1);
                chk("u5_edge18", s5, 1);
                chk("u1_a", u1.a, 3);
                chk("u1_b", u1.b, 5);
                chk("u4_ab", {u4.a, u4.b}, 32'hFFFF_FFFF);
                chk("u5_ab", {u5.a, u5.b}, 32'h0000_0001);
                repeat (17999 - 18) @(posedge clk);
                #1;
                chk("u0_edge17999", s0, 0);
                chk("u1_stays_high", s1, 1);
                @(posedge clk);
                #1;
                chk("u0_edge18000", s0, 1);
                mon0_en = 1'b0;
                chk("u0_queue_drained", q0.size(), 0);
                #2;
                rst_main = 1'b0;
                #1;
                chk("u0_async_drop", s0, 0);
                chk("u1_async_drop", s1, 0);
                chk("u2_err_reset", u2.state, 0);
                push_singles();
                @(negedge clk);
                rst_main = 1'b1;
                repeat (17) @(posedge clk);
                #1;
                chk("u1_rerun_edge17", s1, 0);
                @(posedge clk);
                #1;
                chk("u1_rerun_edge18", s1, 1);
                chk("u4_rerun_edge18", s4, 1);
            end
            begin
                bit hi;
                hi = 1'b0;
                repeat (53) @(posedge clk);
                #1;
                chk("u2_edge53_check", u2.state, 2);
                @(posedge clk);
                #1;
                chk("u2_edge54_error", u2.state, 4);
                repeat (1000) begin
                    @(posedge clk);
                    #1;
                    hi |= s2;
                end
                chk("u2_no_success", hi, 0);
                chk("u2_still_error", u2.state, 4);
            end
            begin
                repeat (100) @(posedge clk);
                #1;
                chk("u3_edge100", s3, 0);
                @(negedge clk);
                rst3 = 1'b0;
                #1;
                chk("u3_rst_state", u3.state, 0);
                chk("u3_rst_iter", u3.iter, 0);
                @(negedge clk);
                rst3 = 1'b1;
                repeat (143) @(posedge clk);
                #1;
                chk("u3_edge143", s3, 0);
                @(posedge clk);
                #1;
                chk("u3_edge144", s3, 1);
            end
        join
        @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("q5_drained", q5.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
